mips_mem_ctrl: RTL and testbench

- Memory controller ("mc") on the core side of the MIPS pipeline. It serves the fetch port (if_mc_*) and the data-memory port (mem_mc_*) of the processor top level.
- Both 32-bit ports are arbitrated onto one external asynchronous 16-bit SRAM.
- Each 32-bit access is split into two halfword SRAM cycles; byte enables select which bytes are written.
- A one-cycle done pulse per port lets the pipeline generate its stalls.

---
 rtl/mips_mem_ctrl_if.sv | 28 ++
 rtl/mips_mem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mips_mem_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_ctrl_if.sv
// Core-side request/response bundle between the pipeline's fetch and data
// ports and the memory controller.
interface mips_mem_ctrl_if;
  logic        if_mc_en;
  logic [31:0] if_mc_addr;
  logic [31:0] mc_if_data;
  logic        if_done;
  logic        mem_mc_en;
  logic        mem_mc_rw;
  logic [31:0] mem_mc_addr;
  logic        mem_mc_en1h;
  logic        mem_mc_en1l;
  logic        mem_mc_en2h;
  logic        mem_mc_en2l;
  logic        mem_done;

  modport master (
    output if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr,
           mem_mc_en1h, mem_mc_en1l, mem_mc_en2h, mem_mc_en2l,
    input  mc_if_data, if_done, mem_done
  );

  modport slave (
    input  if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr,
           mem_mc_en1h, mem_mc_en1l, mem_mc_en2h, mem_mc_en2l,
    output mc_if_data, if_done, mem_done
  );
endinterface

// File: rtl/mips_mem_ctrl.sv
// Arbitrates the fetch and data ports onto one 16-bit asynchronous SRAM,
// splitting each 32-bit access into big-endian HI/LO halfword cycles.
module mips_mem_ctrl #(
  parameter int unsigned SRAM_AW = 18
) (
  input  logic               clock,
  input  logic               reset,
  mips_mem_ctrl_if.slave     core,
  inout  wire  [31:0]        mem_mc_data,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [15:0]        sram_data,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);
  localparam int unsigned WA_W = SRAM_AW - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HI   = 2'd1;
  localparam logic [1:0] S_LO   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;       // 1 = data port owns the transaction
  logic               wr_q, wr_d;
  logic               last_data_q, last_data_d;
  logic [15:0]        hi_q, hi_d;
  logic [31:0]        rd_q, rd_d;
  logic [31:0]        if_data_q, if_data_d;
  logic               if_done_q, if_done_d;
  logic               mem_done_q, mem_done_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               ub_n_q, ub_n_d;
  logic               lb_n_q, lb_n_d;
  logic               drv_q, drv_d;
  logic [15:0]        wdata_q, wdata_d;

  logic               hi_en_c, lo_en_c, sel_data_c;
  logic [31:0]        cur_addr_c;
  logic [WA_W-1:0]    word_addr_c;
  logic               unused_c;

  assign hi_en_c  = core.mem_mc_en1h | core.mem_mc_en1l;
  assign lo_en_c  = core.mem_mc_en2h | core.mem_mc_en2l;
  assign unused_c = ^{cur_addr_c[31:SRAM_AW+1], cur_addr_c[1:0]};

  // Next state, then the registered SRAM strobes for the phase being entered.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    last_data_d = last_data_q;
    hi_d        = hi_q;
    rd_d        = rd_q;
    if_data_d   = if_data_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    addr_d      = addr_q;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    drv_d       = 1'b0;
    wdata_d     = wdata_q;
    sel_data_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (core.if_mc_en || core.mem_mc_en) begin
          sel_data_c = core.mem_mc_en && (!core.if_mc_en || !last_data_q);
          owner_d    = sel_data_c;
          wr_d       = sel_data_c && !core.mem_mc_rw;
          if (!wr_d || hi_en_c) state_d = S_HI;
          else if (lo_en_c)     state_d = S_LO;
          else                  state_d = S_DONE;
        end
      end
      S_HI: begin
        if (!wr_q) hi_d = sram_data;
        state_d = (!wr_q || lo_en_c) ? S_LO : S_DONE;
      end
      S_LO: begin
        if (!wr_q) begin
          if (owner_q) rd_d      = {hi_q, sram_data};
          else         if_data_d = {hi_q, sram_data};
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    cur_addr_c  = owner_d ? core.mem_mc_addr : core.if_mc_addr;
    word_addr_c = cur_addr_c[SRAM_AW:2];

    if (state_d == S_HI || state_d == S_LO) begin
      ce_n_d = 1'b0;
      addr_d = {word_addr_c, 1'(state_d == S_LO)};
      if (wr_d) begin
        we_n_d = 1'b0;
        drv_d  = 1'b1;
        if (state_d == S_HI) begin
          ub_n_d  = ~core.mem_mc_en1h;
          lb_n_d  = ~core.mem_mc_en1l;
          wdata_d = mem_mc_data[31:16];
        end else begin
          ub_n_d  = ~core.mem_mc_en2h;
          lb_n_d  = ~core.mem_mc_en2l;
          wdata_d = mem_mc_data[15:0];
        end
      end else begin
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
    end

    // DONE is only ever entered from another state, so this is a single pulse.
    if (state_d == S_DONE) begin
      if_done_d   = !owner_d;
      mem_done_d  = owner_d;
      last_data_d = owner_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      last_data_q <= 1'b0;
      hi_q        <= 16'h0;
      rd_q        <= 32'h0;
      if_data_q   <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      addr_q      <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      drv_q       <= 1'b0;
      wdata_q     <= 16'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      last_data_q <= last_data_d;
      hi_q        <= hi_d;
      rd_q        <= rd_d;
      if_data_q   <= if_data_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      addr_q      <= addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      drv_q       <= drv_d;
      wdata_q     <= wdata_d;
    end
  end

  assign core.mc_if_data = if_data_q;
  assign core.if_done    = if_done_q;
  assign core.mem_done   = mem_done_q;
  assign sram_addr       = addr_q;
  assign sram_ce_n       = ce_n_q;
  assign sram_oe_n       = oe_n_q;
  assign sram_we_n       = we_n_q;
  assign sram_ub_n       = ub_n_q;
  assign sram_lb_n       = lb_n_q;

  assign sram_data   = drv_q ? wdata_q : {16{1'bz}};
  assign mem_mc_data = (core.mem_mc_en && core.mem_mc_rw) ? rd_q : {32{1'bz}};
endmodule

// File: tb/tb_mips_mem_ctrl.sv
// Bench for mips_mem_ctrl: async SRAM model plus a transaction-level memory
// and arbitration reference model driven by directed and random traffic.
module tb_mips_mem_ctrl;
  localparam int unsigned SRAM_AW = 18;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mips_mem_ctrl_if cif();
  wire  [31:0]        mem_mc_data;
  wire  [15:0]        sram_data;
  logic [SRAM_AW-1:0] sram_addr;
  logic sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic        tb_drv = 1'b0;
  logic [31:0] tb_wdata = 32'h0;
  assign mem_mc_data = tb_drv ? tb_wdata : {32{1'bz}};

  mips_mem_ctrl #(.SRAM_AW(SRAM_AW)) dut (
    .clock(clock), .reset(reset), .core(cif.slave),
    .mem_mc_data(mem_mc_data), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- SRAM model ----------------
  logic [15:0]   sram_mem [0:1023];
  logic [1023:0] sram_wr = '0;
  logic          poke_en = 1'b0;
  logic [9:0]    poke_a  = '0;
  logic [15:0]   poke_v  = '0;
  logic [3:0]    tr_ctl [$];
  logic [17:0]   tr_addr [$];

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 40503 + 12345);
  endfunction

  wire [9:0]  sram_idx = sram_addr[9:0];
  wire [15:0] sram_rd  = sram_wr[sram_idx] ? sram_mem[sram_idx] : init_val(int'(sram_idx));
  wire [15:0] sram_wv  = {sram_ub_n ? sram_rd[15:8] : sram_data[15:8],
                          sram_lb_n ? sram_rd[7:0]  : sram_data[7:0]};
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_rd : {16{1'bz}};

  always @(posedge clock) begin
    if (poke_en) begin
      sram_mem[poke_a] <= poke_v;
      sram_wr[poke_a]  <= 1'b1;
    end else if (!sram_ce_n) begin
      tr_addr.push_back(sram_addr);
      tr_ctl.push_back({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
      if (!sram_we_n) begin
        sram_mem[sram_idx] <= sram_wv;
        sram_wr[sram_idx]  <= 1'b1;
      end
    end
  end

  function automatic logic [15:0] sram_peek(input int a);
    return sram_wr[a] ? sram_mem[a] : init_val(a);
  endfunction

  // ---------------- reference model ----------------
  logic [15:0] model_mem [int];

  function automatic logic [15:0] model_half(input int a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_val(a);
  endfunction

  function automatic int half_idx(input logic [31:0] ba);
    return int'(ba[10:2]) * 2;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] ba);
    return {model_half(half_idx(ba)), model_half(half_idx(ba) + 1)};
  endfunction

  task automatic model_store(input logic [31:0] ba, input logic [31:0] wd, input logic [3:0] en);
    logic [15:0] hv, lv;
    hv = model_half(half_idx(ba));
    lv = model_half(half_idx(ba) + 1);
    if (en[3]) hv[15:8] = wd[31:24];
    if (en[2]) hv[7:0]  = wd[23:16];
    if (en[1]) lv[15:8] = wd[15:8];
    if (en[0]) lv[7:0]  = wd[7:0];
    model_mem[half_idx(ba)]     = hv;
    model_mem[half_idx(ba) + 1] = lv;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int n);
    @(negedge clock); reset = 1'b1;
    repeat (n) @(posedge clock);
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic poke(input int a, input logic [15:0] v);
    @(negedge clock);
    poke_en = 1'b1; poke_a = 10'(a); poke_v = v;
    @(posedge clock); #1 poke_en = 1'b0;
    model_mem[a] = v;
  endtask

  task automatic fetch_txn(input logic [31:0] a, output int lat, output logic [31:0] d,
                           output logic post_busy);
    @(negedge clock);
    tr_addr.delete(); tr_ctl.delete();
    cif.if_mc_addr = a; cif.if_mc_en = 1'b1;
    lat = 0; d = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      if (cif.if_done) begin lat = i; d = cif.mc_if_data; break; end
    end
    @(posedge clock); #1;
    post_busy = cif.if_done | cif.mem_done | !sram_ce_n;
    @(negedge clock); cif.if_mc_en = 1'b0;
  endtask

  task automatic data_txn(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] en, output int lat, output logic [31:0] d,
                          output logic post_busy);
    @(negedge clock);
    tr_addr.delete(); tr_ctl.delete();
    cif.mem_mc_rw = rw; cif.mem_mc_addr = a;
    {cif.mem_mc_en1h, cif.mem_mc_en1l, cif.mem_mc_en2h, cif.mem_mc_en2l} = en;
    tb_wdata = wd; tb_drv = !rw; cif.mem_mc_en = 1'b1;
    lat = 0; d = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      if (cif.mem_done) begin lat = i; d = mem_mc_data; break; end
    end
    @(posedge clock); #1;
    post_busy = cif.if_done | cif.mem_done | !sram_ce_n;
    @(negedge clock); cif.mem_mc_en = 1'b0; tb_drv = 1'b0;
  endtask

  function automatic int we_cycles();
    int n = 0;
    foreach (tr_ctl[k]) if (tr_ctl[k][2] == 1'b0) n++;
    return n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(2);
    @(posedge clock); #1;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      errors++; $display("FAIL reset_strobes got %b want 11111",
                         {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    end
    checks++;
    if (sram_addr !== 18'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", sram_addr); end
    checks++;
    if ({cif.if_done, cif.mem_done} !== 2'b00) begin
      errors++; $display("FAIL reset_done got %b want 00", {cif.if_done, cif.mem_done});
    end
    checks++;
    if (cif.mc_if_data !== 32'h0) begin
      errors++; $display("FAIL reset_if_data got %h want 0", cif.mc_if_data);
    end
  endtask

  task automatic test_fetch();
    int lat; logic [31:0] d; logic busy;
    poke(4, 16'h1234);
    poke(5, 16'h5678);
    fetch_txn(32'h0000_0008, lat, d, busy);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL fetch_latency got %0d want 3", lat); end
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL fetch_data got %h want 12345678", d); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL fetch_rearm got %b want 0", busy); end
    checks++;
    if (tr_addr.size() != 2) begin
      errors++; $display("FAIL fetch_phases got %0d want 2", tr_addr.size());
    end else begin
      checks++;
      if ({tr_addr[0], tr_addr[1]} !== {18'd4, 18'd5}) begin
        errors++; $display("FAIL fetch_addr got %0d,%0d want 4,5", tr_addr[0], tr_addr[1]);
      end
      checks++;
      if ({tr_ctl[0], tr_ctl[1]} !== 8'b0100_0100) begin
        errors++; $display("FAIL fetch_ctl got %b,%b want 0100,0100", tr_ctl[0], tr_ctl[1]);
      end
    end
  endtask

  task automatic test_word_write();
    int lat; logic [31:0] d; logic busy;
    data_txn(1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, d, busy);
    model_store(32'h10, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
    checks++;
    if (we_cycles() !== 2) begin errors++; $display("FAIL wr_we_cycles got %0d want 2", we_cycles()); end
    checks++;
    if ({sram_peek(8), sram_peek(9)} !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_sram got %h%h want deadbeef", sram_peek(8), sram_peek(9));
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_rearm got %b want 0", busy); end
    data_txn(1'b1, 32'h10, 32'h0, 4'h0, lat, d, busy);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", d); end
  endtask

  task automatic test_byte_store();
    int lat; logic [31:0] d; logic busy;
    data_txn(1'b0, 32'h10, 32'h0000_00AB, 4'b0001, lat, d, busy);
    model_store(32'h10, 32'h0000_00AB, 4'b0001);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL byte_latency got %0d want 2", lat); end
    checks++;
    if (tr_addr.size() != 1) begin
      errors++; $display("FAIL byte_phases got %0d want 1", tr_addr.size());
    end else begin
      checks++;
      if ({tr_addr[0], tr_ctl[0]} !== {18'd9, 4'b1010}) begin
        errors++; $display("FAIL byte_phase got addr %0d ctl %b want 9 1010", tr_addr[0], tr_ctl[0]);
      end
    end
    checks++;
    if ({sram_peek(8), sram_peek(9)} !== model_word(32'h10)) begin
      errors++; $display("FAIL byte_sram got %h%h want %h", sram_peek(8), sram_peek(9), model_word(32'h10));
    end
    data_txn(1'b0, 32'h10, 32'hFFFF_FFFF, 4'b0000, lat, d, busy);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL noen_latency got %0d want 1", lat); end
    checks++;
    if (tr_addr.size() != 0) begin errors++; $display("FAIL noen_strobe got %0d want 0", tr_addr.size()); end
  endtask

  task automatic test_arbitration();
    int got[$]; logic [31:0] gotd[$];
    int exp_o[$]; logic [31:0] exp_d[$];
    bit pf; int pd; bit last;
    logic [31:0] fa, da;
    do_reset(2);
    fa = 32'h40; da = 32'h80;
    pf = 1'b1; pd = 2; last = 1'b0;
    repeat (3) begin
      if (pd > 0 && (!pf || !last)) begin
        exp_o.push_back(1); exp_d.push_back(model_word(da)); pd--; last = 1'b1;
      end else begin
        exp_o.push_back(0); exp_d.push_back(model_word(fa)); pf = 1'b0; last = 1'b0;
      end
    end
    @(negedge clock);
    cif.if_mc_addr = fa; cif.if_mc_en = 1'b1;
    cif.mem_mc_addr = da; cif.mem_mc_rw = 1'b1; cif.mem_mc_en = 1'b1; tb_drv = 1'b0;
    for (int i = 0; i < 40 && got.size() < 3; i++) begin
      @(posedge clock); #1;
      if (cif.mem_done) begin got.push_back(1); gotd.push_back(mem_mc_data); end
      if (cif.if_done)  begin got.push_back(0); gotd.push_back(cif.mc_if_data); end
      @(negedge clock);
      if (cif.if_done) cif.if_mc_en = 1'b0;
    end
    cif.if_mc_en = 1'b0; cif.mem_mc_en = 1'b0;
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL arb_count got %0d want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== exp_o[k] || gotd[k] !== exp_d[k]) begin
          errors++; $display("FAIL arb_order[%0d] got owner %0d data %h want owner %0d data %h",
                             k, got[k], gotd[k], exp_o[k], exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] d; logic busy; logic any_done;
    @(negedge clock); cif.if_mc_addr = 32'h20; cif.if_mc_en = 1'b1;
    @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      errors++; $display("FAIL rstmid_strobes got %b want 11111",
                         {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    end
    @(negedge clock); reset = 1'b0; cif.if_mc_en = 1'b0;
    any_done = 1'b0;
    repeat (4) begin @(posedge clock); #1; any_done |= cif.if_done | cif.mem_done; end
    checks++;
    if (any_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", any_done); end
    fetch_txn(32'h24, lat, d, busy);
    checks++;
    if (lat !== 3 || d !== model_word(32'h24)) begin
      errors++; $display("FAIL rstmid_fetch got lat %0d data %h want 3 %h", lat, d, model_word(32'h24));
    end
  endtask

  task automatic test_random();
    int lat, exp_lat, kind; logic [31:0] d, a, wd; logic [3:0] en; logic busy;
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 2));
      a = ($urandom() & 32'hFFF8_0000) | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
      wd = $urandom();
      en = 4'($urandom_range(0, 15));
      if (kind == 0) begin
        fetch_txn(a, lat, d, busy);
        checks++;
        if (lat !== 3 || d !== model_word(a) || busy !== 1'b0) begin
          errors++; $display("FAIL rnd_fetch[%0d] a=%h got lat %0d data %h busy %b want 3 %h 0",
                             n, a, lat, d, busy, model_word(a));
        end
      end else if (kind == 1) begin
        data_txn(1'b1, a, 32'h0, en, lat, d, busy);
        checks++;
        if (lat !== 3 || d !== model_word(a) || busy !== 1'b0) begin
          errors++; $display("FAIL rnd_read[%0d] a=%h got lat %0d data %h busy %b want 3 %h 0",
                             n, a, lat, d, busy, model_word(a));
        end
      end else begin
        data_txn(1'b0, a, wd, en, lat, d, busy);
        model_store(a, wd, en);
        exp_lat = 1 + int'(|en[3:2]) + int'(|en[1:0]);
        checks++;
        if (lat !== exp_lat || we_cycles() !== exp_lat - 1 ||
            {sram_peek(half_idx(a)), sram_peek(half_idx(a) + 1)} !== model_word(a)) begin
          errors++; $display("FAIL rnd_write[%0d] a=%h en=%b got lat %0d we %0d mem %h%h want %0d %0d %h",
                             n, a, en, lat, we_cycles(), sram_peek(half_idx(a)),
                             sram_peek(half_idx(a) + 1), exp_lat, exp_lat - 1, model_word(a));
        end
      end
    end
  endtask

  initial begin
    cif.if_mc_en = 1'b0; cif.if_mc_addr = 32'h0;
    cif.mem_mc_en = 1'b0; cif.mem_mc_rw = 1'b1; cif.mem_mc_addr = 32'h0;
    cif.mem_mc_en1h = 1'b0; cif.mem_mc_en1l = 1'b0;
    cif.mem_mc_en2h = 1'b0; cif.mem_mc_en2l = 1'b0;
    test_reset();
    test_fetch();
    test_word_write();
    test_byte_store();
    test_arbitration();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
